// File: rtl/dmem_port_if.sv
// Data-memory request/response bus between the core (master) and a memory
// responder (slave). One request in flight; the response is a one-cycle pulse.
interface dmem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_mode;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_mode, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_mode, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_port.sv
// Handshaked data-memory responder: accepts one load/store at a time, waits
// LATENCY cycles, then executes it against a word-organised RAM and pulses a
// response carrying the extended load data and an error flag.
module dmem_port #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    dmem_port_if.slave  bus,
    output logic        busy
);
    localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LastCnt = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        init_q;
    logic        we_q;
    logic [2:0]  mode_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, enter_resp;
    logic        cur_we;
    logic [2:0]  cur_mode;
    logic [31:0] cur_addr, cur_wdata;
    logic [IdxW-1:0] idx;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd, word, load_val;
    logic [15:0] lane;

    assign accept        = bus.req_valid && bus.req_ready;
    // Ready stays low until the first edge after reset release.
    assign bus.req_ready = init_q && (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != StIdle);
    assign enter_resp    = (state_d == StResp) && (state_q != StResp);

    // With zero latency the RESP-entry edge is the accept edge, so execute
    // straight from the bus; otherwise use the captured request.
    always_comb begin
        cur_we    = we_q;
        cur_mode  = mode_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == StIdle) begin
            cur_we    = bus.req_we;
            cur_mode  = bus.req_mode;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
    end

    // Request legality, byte enables and load extraction.
    always_comb begin
        idx = cur_addr[IdxW+1:2];
        err = 1'b0;
        if (!(cur_mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) err = 1'b1;
        if (cur_mode[1:0] == 2'b01 && cur_addr[0]) err = 1'b1;
        if (cur_mode[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) err = 1'b1;
        if ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS) err = 1'b1;
        if (cur_we && cur_mode[2]) err = 1'b1;

        be = 4'b1111;
        wd = cur_wdata;
        case (cur_mode[1:0])
            2'b00: begin
                be = 4'b0001 << cur_addr[1:0];
                wd = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be = cur_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase

        word = mem[idx];
        lane = 16'(word >> {cur_addr[1:0], 3'b000});
        case (cur_mode[1:0])
            2'b00:   load_val = {{24{lane[7] & ~cur_mode[2]}}, lane[7:0]};
            2'b01:   load_val = {{16{lane[15] & ~cur_mode[2]}}, lane[15:0]};
            default: load_val = word;
        endcase
    end

    // Next-state logic: accept -> wait LATENCY cycles -> one response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'd0;
                    end
                end
            end
            StWait: begin
                if (cnt_q == LastCnt) state_d = StResp;
                else                  cnt_d   = cnt_q + 4'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, counter, request capture and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            init_q  <= 1'b0;
            we_q    <= 1'b0;
            mode_q  <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
            if (accept) begin
                we_q    <= bus.req_we;
                mode_q  <= bus.req_mode;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (enter_resp) begin
                err_q   <= err;
                rdata_q <= (err || cur_we) ? 32'd0 : load_val;
            end
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (enter_resp && !err && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: a LATENCY=2 instance for functional and
// reset tests, a LATENCY=0 instance for back-to-back throughput.
module tb_dmem_port;
    localparam int unsigned Depth = 1024;

    logic clk = 1'b0;
    logic reset;
    logic busy_a, busy_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Byte-addressed reference memory for the LATENCY=2 instance.
    logic [7:0] ref_mem [Depth*4];

    logic [31:0] rd, rd_after, exp_rd;
    logic        er, exp_er, pok, rir;
    int          lat;

    always #5 clk = ~clk;

    dmem_port_if ia ();
    dmem_port_if ib ();

    dmem_port #(.DEPTH_WORDS(Depth), .LATENCY(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia),
        .busy  (busy_a)
    );

    dmem_port #(.DEPTH_WORDS(Depth), .LATENCY(0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib),
        .busy  (busy_b)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
        $fatal(1);
    end

    // Access semantics from the byte view: size, alignment, range, extension.
    function automatic void model_txn(input logic we, input logic [2:0] mode,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err);
        int size;
        logic [31:0] v;
        size = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
        err = 1'b0;
        if (!(mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) err = 1'b1;
        if (we && mode[2]) err = 1'b1;
        if ((addr % 32'(size)) != 0) err = 1'b1;
        if (addr >= Depth * 4) err = 1'b1;
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + i];
                if (size == 1 && !mode[2]) v = {{24{v[7]}}, v[7:0]};
                if (size == 2 && !mode[2]) v = {{16{v[15]}}, v[15:0]};
                rdata = v;
            end
        end
    endfunction

    // Drive one request into instance A and collect what comes back.
    task automatic run_txn(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int latency, output logic pulse_ok,
                           output logic ready_in_resp, output logic [31:0] rdata_hold);
        int w;
        @(negedge clk);
        w = 0;
        while (ia.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        ia.req_valid = 1'b1;
        ia.req_we    = we;
        ia.req_mode  = mode;
        ia.req_addr  = addr;
        ia.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        ia.req_valid = 1'b0;
        ia.req_we    = 1'($urandom);
        ia.req_mode  = 3'($urandom);
        ia.req_addr  = $urandom;
        ia.req_wdata = $urandom;
        latency = 1;
        while (ia.rsp_valid !== 1'b1 && latency < 40) begin
            @(negedge clk);
            latency++;
        end
        rdata         = ia.rsp_rdata;
        err           = ia.rsp_err;
        ready_in_resp = ia.req_ready;
        @(negedge clk);
        pulse_ok   = (ia.rsp_valid === 1'b0);
        rdata_hold = ia.rsp_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_mode = 3'b010;
        ia.req_addr = 32'd0; ia.req_wdata = 32'd0;
        ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_mode = 3'b010;
        ib.req_addr = 32'd0; ib.req_wdata = 32'd0;
        repeat (3) begin
            @(negedge clk);
            n_checks += 5;
            if (ia.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ia.req_ready); end
            if (ia.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", ia.rsp_valid); end
            if (ia.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", ia.rsp_rdata); end
            if (ia.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", ia.rsp_err); end
            if (busy_a !== 1'b0 || ib.req_ready !== 1'b0) begin
                n_fail++; $display("FAIL rst_busy_b_ready got=%b%b exp=00", busy_a, ib.req_ready);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ia.req_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early got=%b exp=0", ia.req_ready); end
        @(negedge clk);
        n_checks++;
        if (ia.req_ready !== 1'b1 || ib.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rel_ready got=%b%b exp=11", ia.req_ready, ib.req_ready);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (ia.rsp_valid !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++; $display("FAIL idle_quiet got=%b%b exp=00", ia.rsp_valid, busy_a);
            end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr, wdata;
        for (int w = 0; w < 64; w++) begin
            wdata = $urandom;
            model_txn(1'b1, 3'b010, 32'(w * 4), wdata, exp_rd, exp_er);
            run_txn(1'b1, 3'b010, 32'(w * 4), wdata, rd, er, lat, pok, rir, rd_after);
            n_checks++;
            if (er !== 1'b0 || lat != 3) begin
                n_fail++; $display("FAIL init_sw addr=%0h err=%b lat=%0d exp err=0 lat=3", w * 4, er, lat);
            end
        end
        for (int n = 0; n < 80; n++) begin
            we    = 1'($urandom_range(0, 1));
            mode  = 3'($urandom_range(0, 7));
            addr  = ($urandom_range(0, 7) == 0) ? 32'(Depth * 4) + $urandom_range(0, 65535)
                                                : $urandom_range(0, 255);
            wdata = $urandom;
            model_txn(we, mode, addr, wdata, exp_rd, exp_er);
            run_txn(we, mode, addr, wdata, rd, er, lat, pok, rir, rd_after);
            n_checks += 4;
            if (rd !== exp_rd || er !== exp_er) begin
                n_fail++;
                $display("FAIL rand_rsp we=%b mode=%b addr=%h got rdata=%h err=%b exp rdata=%h err=%b",
                         we, mode, addr, rd, er, exp_rd, exp_er);
            end
            if (lat != 3) begin n_fail++; $display("FAIL rand_latency got=%0d exp=3", lat); end
            if (pok !== 1'b1 || rir !== 1'b0) begin
                n_fail++; $display("FAIL rand_pulse got single=%b ready_in_resp=%b exp 1,0", pok, rir);
            end
            if (rd_after !== rd) begin n_fail++; $display("FAIL rand_hold got=%h exp=%h", rd_after, rd); end
        end
    endtask

    task automatic test_word();
        model_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, exp_rd, exp_er);
        run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, pok, rir, rd_after);
        n_checks += 2;
        if (lat != 3 || pok !== 1'b1) begin
            n_fail++; $display("FAIL sw_timing got lat=%0d single=%b exp lat=3 single=1", lat, pok);
        end
        if (er !== 1'b0 || rd !== 32'd0) begin
            n_fail++; $display("FAIL sw_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd);
        end
        model_txn(1'b0, 3'b010, 32'h10, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks += 2;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++; $display("FAIL lw_rt got=%h err=%b exp=deadbeef err=0", rd, er);
        end
        if (lat != 3) begin n_fail++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_subword();
        model_txn(1'b1, 3'b010, 32'h20, 32'h11223344, exp_rd, exp_er);
        run_txn(1'b1, 3'b010, 32'h20, 32'h11223344, rd, er, lat, pok, rir, rd_after);
        model_txn(1'b1, 3'b000, 32'h21, 32'hFFFFFF80, exp_rd, exp_er);
        run_txn(1'b1, 3'b000, 32'h21, 32'hFFFFFF80, rd, er, lat, pok, rir, rd_after);
        model_txn(1'b0, 3'b000, 32'h21, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b000, 32'h21, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks++;
        if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got=%h exp=ffffff80", rd); end
        model_txn(1'b0, 3'b100, 32'h21, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b100, 32'h21, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks++;
        if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu got=%h exp=00000080", rd); end
        model_txn(1'b1, 3'b001, 32'h22, 32'h55558001, exp_rd, exp_er);
        run_txn(1'b1, 3'b001, 32'h22, 32'h55558001, rd, er, lat, pok, rir, rd_after);
        model_txn(1'b0, 3'b001, 32'h22, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b001, 32'h22, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks++;
        if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh got=%h exp=ffff8001", rd); end
        model_txn(1'b0, 3'b101, 32'h22, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b101, 32'h22, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks++;
        if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu got=%h exp=00008001", rd); end
        model_txn(1'b0, 3'b010, 32'h20, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks++;
        if (rd !== 32'h80018044) begin n_fail++; $display("FAIL sub_other_bytes got=%h exp=80018044", rd); end
    endtask

    task automatic test_errors();
        logic        t_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  t_mode [6] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100, 3'b111};
        logic [31:0] t_addr [6] = '{32'h13, 32'h11, 32'h10, 32'(Depth * 4), 32'h10, 32'h14};
        for (int i = 0; i < 6; i++) begin
            model_txn(t_we[i], t_mode[i], t_addr[i], 32'h0BADF00D, exp_rd, exp_er);
            run_txn(t_we[i], t_mode[i], t_addr[i], 32'h0BADF00D, rd, er, lat, pok, rir, rd_after);
            n_checks++;
            if (er !== 1'b1 || rd !== 32'd0 || lat != 3) begin
                n_fail++;
                $display("FAIL err_case%0d got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=3",
                         i, er, rd, lat);
            end
        end
        model_txn(1'b0, 3'b010, 32'h10, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++; $display("FAIL err_no_write got=%h err=%b exp=deadbeef err=0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic        q_we    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  q_mode  [4] = '{3'b010, 3'b010, 3'b010, 3'b101};
        logic [31:0] q_addr  [4] = '{32'h40, 32'h44, 32'h40, 32'h46};
        logic [31:0] q_wdata [4] = '{32'hCAFEF00D, 32'h01020304, 32'd0, 32'd0};
        int idx = 0;
        int accepts = 0;
        logic exp_ready, exp_rsp;
        @(negedge clk);
        ib.req_valid = 1'b1;
        ib.req_we = q_we[0]; ib.req_mode = q_mode[0];
        ib.req_addr = q_addr[0]; ib.req_wdata = q_wdata[0];
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk);
            exp_rsp   = (t < 8) && (t % 2 == 1);
            exp_ready = !exp_rsp;
            n_checks++;
            if (ib.req_ready !== exp_ready || ib.rsp_valid !== exp_rsp) begin
                n_fail++;
                $display("FAIL b2b_t%0d got ready=%b rsp=%b exp ready=%b rsp=%b",
                         t, ib.req_ready, ib.rsp_valid, exp_ready, exp_rsp);
            end
            if (t == 5 || t == 7) begin
                n_checks++;
                if (ib.rsp_rdata !== ((t == 5) ? 32'hCAFEF00D : 32'h00000102) || ib.rsp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_rdata_t%0d got=%h err=%b exp=%h err=0", t, ib.rsp_rdata,
                             ib.rsp_err, (t == 5) ? 32'hCAFEF00D : 32'h00000102);
                end
            end
            if (ib.req_valid === 1'b1 && ib.req_ready === 1'b1) begin
                accepts++;
                @(posedge clk);
                #1;
                idx++;
                if (idx < 4) begin
                    ib.req_we = q_we[idx]; ib.req_mode = q_mode[idx];
                    ib.req_addr = q_addr[idx]; ib.req_wdata = q_wdata[idx];
                end else begin
                    ib.req_valid = 1'b0;
                end
            end
        end
        n_checks++;
        if (accepts != 4) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=4", accepts); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_mode = 3'b010;
        ia.req_addr = 32'h30; ia.req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        ia.req_valid = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy_a); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || ia.rsp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL mid_async got busy=%b rdata=%h exp 0,0", busy_a, ia.rsp_rdata);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (ia.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp got=%b exp=0", ia.rsp_valid); end
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ia.rsp_valid !== 1'b0 || ia.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_release got rsp=%b ready=%b exp 0,1", ia.rsp_valid, ia.req_ready);
        end
        model_txn(1'b0, 3'b010, 32'h30, 32'd0, exp_rd, exp_er);
        run_txn(1'b0, 3'b010, 32'h30, 32'd0, rd, er, lat, pok, rir, rd_after);
        n_checks++;
        if (rd !== exp_rd || rd === 32'h12345678) begin
            n_fail++; $display("FAIL mid_dropped_store got=%h exp=%h", rd, exp_rd);
        end
    endtask

    initial begin
        test_reset();
        test_random();
        test_word();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
